// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between the EX stage and a simple data-memory port.
//
// Accepts one EX result at a time.  ALU results are forwarded to writeback
// one cycle later.  Loads and stores are issued to memory with a req/gnt
// handshake; load data returns with rvalid and is formatted (byte/half
// select, sign/zero extension) before writeback.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   valid_i / ready_o        EX-result handshake (ready only when IDLE)
//   alu_result_i             ALU result / effective address
//   rs2_data_i               store data
//   funct3_i                 RV32I access size and sign
//   is_load_i, is_store_i    op class (both 0 = plain ALU op)
//   rd_addr_i, reg_we_i      destination register and write enable
//   dmem_req_o .. dmem_wstrb_o   memory request side
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i   memory response side
//   wb_valid_o .. wb_err_o   one-cycle writeback pulse and payload
//
// Configuration
//   LSU_MISALIGN_CHECK_EN    when defined, misaligned halves/words and
//                            reserved funct3 encodings complete without a
//                            memory access, with wb_err_o=1 and the address
//                            as writeback data.  When undefined the low
//                            address bits are ignored and wb_err_o stays 0.
// ---------------------------------------------------------------------------
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [2:0]      funct3_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            reg_we_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_wstrb_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            wb_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // captured transaction
    logic [XLEN-1:0] addr_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            reg_we_q;

    // writeback registers
    logic            wb_valid_q;
    logic            wb_we_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            wb_err_q;

    logic            accept;
    logic            is_mem;
    logic            misalign;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign accept = valid_i && (state_q == IDLE);
    assign is_mem = is_load_i || is_store_i;

    // Store lane replication and byte enables.  The half offset uses only
    // a[1], so an odd half address is silently rounded down.
    always_comb begin
        st_wdata = rs2_data_i;
        st_wstrb = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data_i[7:0]}};
                st_wstrb = 4'b0001 << alu_result_i[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_data_i[15:0]}};
                st_wstrb = 4'b0011 << {alu_result_i[1], 1'b0};
            end
            default: begin
                st_wdata = rs2_data_i;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Misaligned or reserved-encoding memory op.  Only meaningful when
    // is_mem is set; the default build never flags anything.
    always_comb begin
        misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (is_store_i) begin
            if (funct3_i[2] || (funct3_i == 3'b011))
                misalign = 1'b1;
        end else if (is_load_i) begin
            if ((funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111))
                misalign = 1'b1;
        end
        if ((funct3_i[1:0] == 2'b01) && alu_result_i[0])
            misalign = 1'b1;
        if ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00))
            misalign = 1'b1;
`endif
    end

    // Load data formatting from the captured address offset and funct3.
    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (addr_lo_q)
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = addr_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_data = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.  rvalid is only looked at in WAIT, so a stray
    // response during REQ (or after a reset) cannot complete anything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && is_mem && !misalign) state_d = REQ;
            REQ:  if (dmem_gnt_i) state_d = we_q ? IDLE : WAIT;
            WAIT: if (dmem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and writeback payload.  wb_valid defaults low so it
    // is a single-cycle pulse; the rest of the wb_* fields hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem || misalign) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= !is_mem && reg_we_i;
                            wb_rd_q    <= rd_addr_i;
                            wb_data_q  <= alu_result_i;
                            wb_err_q   <= is_mem;
                        end else begin
                            addr_q    <= {alu_result_i[XLEN-1:2], 2'b00};
                            addr_lo_q <= alu_result_i[1:0];
                            wdata_q   <= is_store_i ? st_wdata : '0;
                            wstrb_q   <= is_store_i ? st_wstrb : 4'b0000;
                            we_q      <= is_store_i;
                            funct3_q  <= funct3_i;
                            rd_q      <= rd_addr_i;
                            reg_we_q  <= reg_we_i;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i && we_q) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= 1'b0;
                        wb_rd_q    <= rd_q;
                        wb_err_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= reg_we_q;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= ld_data;
                        wb_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = we_q && (state_q == REQ);
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_wstrb_o = wstrb_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_rd_addr_o = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign wb_err_o     = wb_err_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu.  Directed scenarios plus a random
// mix of ALU ops, loads and stores checked against a byte-lane reference
// model.  Honors LSU_MISALIGN_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] alu_result_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        is_load_i = 1'b0;
    logic        is_store_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        reg_we_i = 1'b0;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_err_o;

    int total = 0;
    int bad   = 0;

    // observations recorded by drive_op
    int          obs_lat;
    int          obs_req_cycles;
    int          obs_first_req;
    logic        obs_req_seen;
    logic        obs_stable;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we;
    logic        obs_got_wb;
    logic        obs_wb_we;
    logic [4:0]  obs_wb_rd;
    logic [31:0] obs_wb_data;
    logic        obs_wb_err;
    logic        obs_wb_after;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .funct3_i(funct3_i),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .rd_addr_i(rd_addr_i),
        .reg_we_i(reg_we_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_addr_o(wb_rd_addr_o),
        .wb_data_o(wb_data_o), .wb_err_o(wb_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // first byte lane touched; the design rounds halves/words down
    function automatic int first_lane(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = access_bytes(f3);
        return ((a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        int lo, n;
        lo = first_lane(f3, a);
        n  = access_bytes(f3);
        for (int i = 0; i < 4; i++) s[i] = (i >= lo) && (i < lo + n);
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] v);
        if (access_bytes(f3) == 1) return (v & 32'hFF) * 32'h01010101;
        if (access_bytes(f3) == 2) return (v & 32'hFFFF) * 32'h00010001;
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        int n;
        n = access_bytes(f3);
        if (n == 4) return rdata;
        v = (rdata >> (8 * first_lane(f3, a))) & ((n == 1) ? 32'hFF : 32'hFFFF);
        if (!f3[2] && n == 1 && v >= 128)   v = v - 256;
        if (!f3[2] && n == 2 && v >= 32768) v = v - 65536;
        return v;
    endfunction

    function automatic logic model_misalign(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        int n;
        n = access_bytes(f3);
        return (a % n) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- stimulus driver with memory responder ----------------
    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] rs2,
                            input logic [4:0] rd, input logic rwe,
                            input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, input logic rv_in_req);
        logic granted;
        int   wait_cyc;
        obs_lat = -1; obs_req_cycles = 0; obs_first_req = -1;
        obs_req_seen = 0; obs_stable = 1; obs_got_wb = 0;
        obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_we = 0;
        obs_wb_we = 0; obs_wb_rd = '0; obs_wb_data = '0; obs_wb_err = 0;
        granted = 0; wait_cyc = 0;
        @(negedge clk);
        valid_i = 1; is_load_i = ld; is_store_i = st; funct3_i = f3;
        alu_result_i = a; rs2_data_i = rs2; rd_addr_i = rd; reg_we_i = rwe;
        @(negedge clk);
        valid_i = 0; is_load_i = 0; is_store_i = 0;
        alu_result_i = $urandom; rs2_data_i = $urandom;
        for (int c = 0; c < 300; c++) begin
            if (wb_valid_o) begin
                obs_got_wb = 1; obs_lat = c; obs_wb_we = wb_we_o; obs_wb_rd = wb_rd_addr_o;
                obs_wb_data = wb_data_o; obs_wb_err = wb_err_o;
                break;
            end
            dmem_gnt_i = 0; dmem_rvalid_i = 0;
            if (dmem_req_o) begin
                if (!obs_req_seen) begin
                    obs_first_req = c; obs_addr = dmem_addr_o; obs_wdata = dmem_wdata_o;
                    obs_wstrb = dmem_wstrb_o; obs_we = dmem_we_o;
                end else if (dmem_addr_o !== obs_addr || dmem_wdata_o !== obs_wdata ||
                             dmem_wstrb_o !== obs_wstrb || dmem_we_o !== obs_we) begin
                    obs_stable = 0;
                end
                obs_req_seen = 1;
                obs_req_cycles++;
                if (obs_req_cycles > gnt_dly) begin
                    dmem_gnt_i = 1; granted = 1;
                end else if (rv_in_req) begin
                    dmem_rvalid_i = 1; dmem_rdata_i = ~rdata;
                end
            end else if (granted) begin
                wait_cyc++;
                if (wait_cyc > rv_dly) begin
                    dmem_rvalid_i = 1; dmem_rdata_i = rdata;
                end
            end
            @(negedge clk);
        end
        dmem_gnt_i = 0; dmem_rvalid_i = 0;
        @(negedge clk);
        obs_wb_after = wb_valid_o;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 0;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", ready_o); end
        total++; if ({dmem_req_o, dmem_we_o} !== 2'b00) begin bad++; $display("[TB] FAIL reset_req_we got=%b exp=00", {dmem_req_o, dmem_we_o}); end
        total++; if ({dmem_addr_o, dmem_wdata_o, dmem_wstrb_o} !== 68'd0) begin bad++; $display("[TB] FAIL reset_dmem_data got=%h exp=0", {dmem_addr_o, dmem_wdata_o, dmem_wstrb_o}); end
        total++; if ({wb_valid_o, wb_we_o, wb_err_o} !== 3'b000) begin bad++; $display("[TB] FAIL reset_wb_flags got=%b exp=000", {wb_valid_o, wb_we_o, wb_err_o}); end
        total++; if ({wb_rd_addr_o, wb_data_o} !== 37'd0) begin bad++; $display("[TB] FAIL reset_wb_data got=%h exp=0", {wb_rd_addr_o, wb_data_o}); end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_alu;
        drive_op(0, 0, 3'b000, 32'h12345678, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, 1'b0);
        total++; if (obs_got_wb !== 1'b1 || obs_lat != 0) begin bad++; $display("[TB] FAIL alu_latency got=%0d exp=0", obs_lat); end
        total++; if (obs_req_seen !== 1'b0) begin bad++; $display("[TB] FAIL alu_no_req got=%b exp=0", obs_req_seen); end
        total++; if (obs_wb_data !== 32'h12345678) begin bad++; $display("[TB] FAIL alu_data got=%h exp=12345678", obs_wb_data); end
        total++; if (obs_wb_rd !== 5'd5 || obs_wb_we !== 1'b1 || obs_wb_err !== 1'b0) begin bad++; $display("[TB] FAIL alu_rd_we_err got=%0d/%b/%b exp=5/1/0", obs_wb_rd, obs_wb_we, obs_wb_err); end
        total++; if (obs_wb_after !== 1'b0) begin bad++; $display("[TB] FAIL alu_pulse got=%b exp=0", obs_wb_after); end
    endtask

    task automatic test_store_sb;
        drive_op(0, 1, 3'b000, 32'h103, 32'h000000AB, 5'd7, 1'b1, 3, 0, 32'h0, 1'b0);
        total++; if (obs_first_req != 0 || obs_req_cycles != 4) begin bad++; $display("[TB] FAIL sb_req_cycles got=%0d/%0d exp=0/4", obs_first_req, obs_req_cycles); end
        total++; if (obs_stable !== 1'b1) begin bad++; $display("[TB] FAIL sb_stable got=%b exp=1", obs_stable); end
        total++; if (obs_addr !== 32'h100 || obs_we !== 1'b1) begin bad++; $display("[TB] FAIL sb_addr_we got=%h/%b exp=100/1", obs_addr, obs_we); end
        total++; if (obs_wdata !== 32'hABABABAB || obs_wstrb !== 4'b1000) begin bad++; $display("[TB] FAIL sb_wdata_strb got=%h/%b exp=abababab/1000", obs_wdata, obs_wstrb); end
        total++; if (obs_got_wb !== 1'b1 || obs_lat != 4 || obs_wb_we !== 1'b0) begin bad++; $display("[TB] FAIL sb_wb got=%b/%0d/%b exp=1/4/0", obs_got_wb, obs_lat, obs_wb_we); end
        total++; if (obs_wb_after !== 1'b0) begin bad++; $display("[TB] FAIL sb_pulse got=%b exp=0", obs_wb_after); end
    endtask

    task automatic test_load_byte;
        drive_op(1, 0, 3'b000, 32'h201, 32'h0, 5'd9, 1'b1, 1, 1, 32'h000080FF, 1'b0);
        total++; if (obs_addr !== 32'h200 || obs_we !== 1'b0) begin bad++; $display("[TB] FAIL lb_addr got=%h/%b exp=200/0", obs_addr, obs_we); end
        total++; if (obs_wb_data !== 32'hFFFFFF80) begin bad++; $display("[TB] FAIL lb_data got=%h exp=ffffff80", obs_wb_data); end
        total++; if (obs_wb_rd !== 5'd9 || obs_wb_we !== 1'b1 || obs_lat != 4) begin bad++; $display("[TB] FAIL lb_wb got=%0d/%b/%0d exp=9/1/4", obs_wb_rd, obs_wb_we, obs_lat); end
        drive_op(1, 0, 3'b100, 32'h201, 32'h0, 5'd10, 1'b1, 0, 0, 32'h000080FF, 1'b0);
        total++; if (obs_wb_data !== 32'h00000080) begin bad++; $display("[TB] FAIL lbu_data got=%h exp=00000080", obs_wb_data); end
    endtask

    task automatic test_load_half;
        drive_op(1, 0, 3'b001, 32'h202, 32'h0, 5'd11, 1'b1, 2, 2, 32'h80010000, 1'b1);
        total++; if (obs_got_wb !== 1'b1 || obs_lat != 6) begin bad++; $display("[TB] FAIL lh_rvalid_in_req got=%b/%0d exp=1/6", obs_got_wb, obs_lat); end
        total++; if (obs_wb_data !== 32'hFFFF8001) begin bad++; $display("[TB] FAIL lh_data got=%h exp=ffff8001", obs_wb_data); end
        drive_op(1, 0, 3'b101, 32'h202, 32'h0, 5'd12, 1'b0, 0, 1, 32'h80010000, 1'b1);
        total++; if (obs_wb_data !== 32'h00008001 || obs_wb_we !== 1'b0) begin bad++; $display("[TB] FAIL lhu_data got=%h/%b exp=00008001/0", obs_wb_data, obs_wb_we); end
    endtask

    task automatic test_misalign;
        drive_op(1, 0, 3'b010, 32'h302, 32'h0, 5'd13, 1'b1, 1, 0, 32'hCAFEF00D, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
        total++; if (obs_req_seen !== 1'b0 || obs_lat != 0) begin bad++; $display("[TB] FAIL lw_mis_noreq got=%b/%0d exp=0/0", obs_req_seen, obs_lat); end
        total++; if (obs_wb_err !== 1'b1 || obs_wb_we !== 1'b0) begin bad++; $display("[TB] FAIL lw_mis_err got=%b/%b exp=1/0", obs_wb_err, obs_wb_we); end
        total++; if (obs_wb_data !== 32'h302) begin bad++; $display("[TB] FAIL lw_mis_data got=%h exp=302", obs_wb_data); end
        drive_op(1, 0, 3'b011, 32'h400, 32'h0, 5'd14, 1'b1, 0, 0, 32'h0, 1'b0);
        total++; if (obs_req_seen !== 1'b0 || obs_wb_err !== 1'b1) begin bad++; $display("[TB] FAIL ld_f3_011 got=%b/%b exp=0/1", obs_req_seen, obs_wb_err); end
`else
        total++; if (obs_req_seen !== 1'b1 || obs_addr !== 32'h300) begin bad++; $display("[TB] FAIL lw_noalign_addr got=%b/%h exp=1/300", obs_req_seen, obs_addr); end
        total++; if (obs_wb_data !== 32'hCAFEF00D || obs_wb_err !== 1'b0) begin bad++; $display("[TB] FAIL lw_noalign_data got=%h/%b exp=cafef00d/0", obs_wb_data, obs_wb_err); end
`endif
    endtask

    task automatic test_reset_mid;
        logic seen_req;
        logic late_wb;
        seen_req = 0; late_wb = 0;
        @(negedge clk);
        valid_i = 1; is_load_i = 1; funct3_i = 3'b010; alu_result_i = 32'h500; rd_addr_i = 5'd3; reg_we_i = 1;
        @(negedge clk);
        valid_i = 0; is_load_i = 0;
        for (int c = 0; c < 20 && !seen_req; c++) begin
            if (dmem_req_o) seen_req = 1; else @(negedge clk);
        end
        total++; if (seen_req !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_req_timeout got=%b exp=1", seen_req); end
        dmem_gnt_i = 1;
        @(negedge clk);
        dmem_gnt_i = 0;
        #2 rst = 0;
        #1;
        total++; if ({dmem_req_o, dmem_we_o, wb_valid_o, wb_we_o, wb_err_o} !== 5'd0 || ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_flags got=%b/%b exp=00000/1", {dmem_req_o, dmem_we_o, wb_valid_o, wb_we_o, wb_err_o}, ready_o); end
        total++; if ({dmem_addr_o, dmem_wstrb_o, wb_rd_addr_o, wb_data_o} !== 73'd0) begin bad++; $display("[TB] FAIL rstmid_data got=%h exp=0", {dmem_addr_o, dmem_wstrb_o, wb_rd_addr_o, wb_data_o}); end
        @(negedge clk);
        rst = 1;
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h5555AAAA;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dmem_rvalid_i = 0;
            if (wb_valid_o) late_wb = 1;
        end
        total++; if (late_wb !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_late_rvalid got=%b exp=0", late_wb); end
    endtask

    task automatic test_random;
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [31:0] a, rs2, rdata;
        logic [4:0]  rd;
        logic        rwe, rvreq, mis;
        int          kind, gd, rd_dly;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a = $urandom; rs2 = $urandom; rdata = $urandom; rd = 5'($urandom);
            rwe = 1'($urandom); rvreq = 1'($urandom);
            gd = $urandom_range(0, 3); rd_dly = $urandom_range(0, 3);
            drive_op(kind == 1, kind == 2, f3, a, rs2, rd, rwe, gd, rd_dly, rdata, rvreq);
            mis = (kind != 0) && model_misalign(f3, a);
            total++; if (obs_got_wb !== 1'b1 || obs_wb_after !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_pulse got=%b/%b exp=1/0", n, obs_got_wb, obs_wb_after); end
            if (kind == 0 || mis) begin
                total++; if (obs_req_seen !== 1'b0 || obs_lat != 0) begin bad++; $display("[TB] FAIL rnd%0d_direct got=%b/%0d exp=0/0", n, obs_req_seen, obs_lat); end
                total++; if (obs_wb_data !== a || obs_wb_err !== mis || obs_wb_we !== (rwe && !mis) || obs_wb_rd !== rd) begin bad++; $display("[TB] FAIL rnd%0d_direct_wb got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", n, obs_wb_data, obs_wb_err, obs_wb_we, obs_wb_rd, a, mis, rwe && !mis, rd); end
            end else if (kind == 2) begin
                total++; if (obs_addr !== (a & 32'hFFFFFFFC) || obs_we !== 1'b1 || obs_stable !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_st_req got=%h/%b/%b exp=%h/1/1", n, obs_addr, obs_we, obs_stable, a & 32'hFFFFFFFC); end
                total++; if (obs_wdata !== model_wdata(f3, rs2) || obs_wstrb !== model_strb(f3, a)) begin bad++; $display("[TB] FAIL rnd%0d_st_data got=%h/%b exp=%h/%b", n, obs_wdata, obs_wstrb, model_wdata(f3, rs2), model_strb(f3, a)); end
                total++; if (obs_lat != gd + 1 || obs_wb_we !== 1'b0 || obs_wb_err !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_st_wb got=%0d/%b/%b exp=%0d/0/0", n, obs_lat, obs_wb_we, obs_wb_err, gd + 1); end
            end else begin
                total++; if (obs_addr !== (a & 32'hFFFFFFFC) || obs_we !== 1'b0 || obs_stable !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_ld_req got=%h/%b/%b exp=%h/0/1", n, obs_addr, obs_we, obs_stable, a & 32'hFFFFFFFC); end
                total++; if (obs_wb_data !== model_load(f3, a, rdata)) begin bad++; $display("[TB] FAIL rnd%0d_ld_data f3=%0d a=%h got=%h exp=%h", n, f3, a, obs_wb_data, model_load(f3, a, rdata)); end
                total++; if (obs_lat != gd + rd_dly + 2 || obs_wb_we !== rwe || obs_wb_rd !== rd || obs_wb_err !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_ld_wb got=%0d/%b/%0d/%b exp=%0d/%b/%0d/0", n, obs_lat, obs_wb_we, obs_wb_rd, obs_wb_err, gd + rd_dly + 2, rwe, rd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_sb();
        test_load_byte();
        test_load_half();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
